// File: rtl/cmd_router_pkg.sv
// Shared types, widths and helpers for the custom-instruction router.
package cmd_router_pkg;

  localparam int FUNC_ID_W = 10;
  localparam int DATA_W    = 32;

  localparam logic [DATA_W-1:0] ERR_RSP_DEFAULT = 32'hDEAD_0BAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } state_t;

  // Slot number sits in the top sel_w bits of the function id.
  function automatic logic [FUNC_ID_W-1:0] sel_of(input logic [FUNC_ID_W-1:0] function_id,
                                                  input int sel_w);
    return function_id >> (FUNC_ID_W - sel_w);
  endfunction

endpackage

// File: rtl/cmd_router_wdog.sv
// Response watchdog: counts cycles while enabled, expires on the last allowed cycle.
module cmd_router_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // Saturates at TIMEOUT_CYCLES; a zero limit pins the count at 0.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && count != SAT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/cmd_router.sv
// Routes CPU custom instructions to one of NUM_SLOTS slots, one command in flight,
// with unmapped-slot errors, response watchdog, stale-response dropping and IRQ OR.
//
// state | meaning
// IDLE  | ready for a new command (or holding one aimed at a stale slot)
// WAIT  | command issued to slot own, waiting for its response or the watchdog
// RSP   | response registered, waiting for the CPU to take it
module cmd_router
  import cmd_router_pkg::*;
#(
  parameter int                  NUM_SLOTS      = 4,
  parameter logic [NUM_SLOTS-1:0] SLOT_EN       = 4'b0011,
  parameter int                  TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0]   ERR_RSP        = ERR_RSP_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  input  logic [FUNC_ID_W-1:0]        cmd_function_id,
  input  logic [DATA_W-1:0]           cmd_inputs_0,
  input  logic [DATA_W-1:0]           cmd_inputs_1,
  output logic                        cmd_ready,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_outputs_0,
  input  logic                        rsp_ready,
  output logic                        cmd_int,
  output logic [NUM_SLOTS-1:0]        s_cmd_valid,
  input  logic [NUM_SLOTS-1:0]        s_cmd_ready,
  output logic [FUNC_ID_W-1:0]        s_cmd_function_id,
  output logic [DATA_W-1:0]           s_cmd_inputs_0,
  output logic [DATA_W-1:0]           s_cmd_inputs_1,
  input  logic [NUM_SLOTS-1:0]        s_rsp_valid,
  input  logic [DATA_W*NUM_SLOTS-1:0] s_rsp_outputs_0,
  output logic [NUM_SLOTS-1:0]        s_rsp_ready,
  input  logic [NUM_SLOTS-1:0]        s_cmd_int,
  output logic                        timeout_flag,
  input  logic                        timeout_clr
);

  localparam int SEL_W = $clog2(NUM_SLOTS);

  state_t               state;
  logic [SEL_W-1:0]     own;
  logic [NUM_SLOTS-1:0] stale;
  logic [SEL_W-1:0]     sel;
  logic                 sel_en;
  logic                 sel_stale;
  logic                 cmd_hs;
  logic                 own_rsp;
  logic [DATA_W-1:0]    own_data;
  logic                 wdog_expire;

  assign sel       = SEL_W'(sel_of(cmd_function_id, SEL_W));
  assign sel_en    = SLOT_EN[sel];
  assign sel_stale = stale[sel];
  assign cmd_hs    = (state == IDLE) && sel_en && !sel_stale && cmd_valid && s_cmd_ready[sel];
  assign own_rsp   = s_rsp_valid[own];
  assign own_data  = s_rsp_outputs_0[{own, 5'b0} +: DATA_W];

  assign s_cmd_function_id = cmd_function_id;
  assign s_cmd_inputs_0    = cmd_inputs_0;
  assign s_cmd_inputs_1    = cmd_inputs_1;

  always_comb begin
    s_cmd_valid = '0;
    cmd_ready   = 1'b0;
    s_rsp_ready = stale;
    case (state)
      IDLE: begin
        if (!sel_en) begin
          cmd_ready = 1'b1;
        end else if (!sel_stale) begin
          s_cmd_valid[sel] = cmd_valid;
          cmd_ready        = s_cmd_ready[sel];
        end
      end
      WAIT:    s_rsp_ready[own] = 1'b1;
      default: ;
    endcase
  end

  cmd_router_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr   (cmd_hs),
    .en    ((state == WAIT) && !own_rsp),
    .expire(wdog_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      own           <= '0;
      stale         <= '0;
      rsp_valid     <= 1'b0;
      rsp_outputs_0 <= '0;
      cmd_int       <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      cmd_int <= |(s_cmd_int & SLOT_EN);
      // Late responses from abandoned slots are swallowed here.
      stale   <= stale & ~s_rsp_valid;
      if (timeout_clr) timeout_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && !sel_en) begin
            rsp_outputs_0 <= ERR_RSP;
            rsp_valid     <= 1'b1;
            state         <= RSP;
          end else if (cmd_hs) begin
            own   <= sel;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (own_rsp) begin
            rsp_outputs_0 <= own_data;
            rsp_valid     <= 1'b1;
            state         <= RSP;
          end else if (wdog_expire) begin
            rsp_outputs_0 <= ERR_RSP;
            rsp_valid     <= 1'b1;
            timeout_flag  <= 1'b1;
            stale[own]    <= 1'b1;
            state         <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_router.sv
// Directed bench for cmd_router with a transaction-level reference model checked every cycle.
module tb_cmd_router;

  localparam int          TO  = 16;
  localparam logic [3:0]  EN  = 4'b0011;
  localparam logic [31:0] ERR = 32'hDEAD_0BAD;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic [9:0]   cmd_function_id;
  logic [31:0]  cmd_inputs_0, cmd_inputs_1;
  logic         cmd_ready, rsp_valid, rsp_ready, cmd_int;
  logic [31:0]  rsp_outputs_0;
  logic [3:0]   s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready, s_cmd_int;
  logic [9:0]   s_cmd_function_id;
  logic [31:0]  s_cmd_inputs_0, s_cmd_inputs_1;
  logic [127:0] s_rsp_outputs_0;
  logic         timeout_flag, timeout_clr;

  always #5 clk = ~clk;

  cmd_router #(
    .NUM_SLOTS(4), .SLOT_EN(EN), .TIMEOUT_CYCLES(TO), .ERR_RSP(ERR)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_function_id(cmd_function_id),
    .cmd_inputs_0(cmd_inputs_0), .cmd_inputs_1(cmd_inputs_1), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_outputs_0(rsp_outputs_0), .rsp_ready(rsp_ready),
    .cmd_int(cmd_int), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_function_id(s_cmd_function_id), .s_cmd_inputs_0(s_cmd_inputs_0),
    .s_cmd_inputs_1(s_cmd_inputs_1), .s_rsp_valid(s_rsp_valid),
    .s_rsp_outputs_0(s_rsp_outputs_0), .s_rsp_ready(s_rsp_ready), .s_cmd_int(s_cmd_int),
    .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [31:0] d);
    s_rsp_outputs_0[i*32 +: 32] = d;
  endtask

  // Reference model: who is busy, how long it has waited, what answer is owed to the CPU.
  bit          m_have, m_flag, m_int, cmp_en = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_stale;
  int          m_busy = -1;
  int          m_waited;

  always @(posedge clk) begin : model
    int sel;
    bit to_now;
    logic [3:0] old_stale;
    if (reset) begin
      m_have = 0; m_data = '0; m_busy = -1; m_waited = 0;
      m_stale = '0; m_flag = 0; m_int = 0; cmp_en = 1;
    end else begin
      sel = int'(cmd_function_id[9:8]);
      old_stale = m_stale;
      to_now = 0;
      m_int = |(s_cmd_int & EN);
      m_stale = m_stale & ~s_rsp_valid;
      if (m_have) begin
        if (rsp_ready) m_have = 0;
      end else if (m_busy >= 0) begin
        if (s_rsp_valid[m_busy]) begin
          m_data = s_rsp_outputs_0[m_busy*32 +: 32];
          m_have = 1; m_busy = -1;
        end else if (m_waited == TO - 1) begin
          m_data = ERR; m_have = 1; to_now = 1;
          m_stale[m_busy] = 1'b1; m_busy = -1;
        end else begin
          m_waited++;
        end
      end else if (cmd_valid) begin
        if (!EN[sel]) begin
          m_data = ERR; m_have = 1;
        end else if (!old_stale[sel] && s_cmd_ready[sel]) begin
          m_busy = sel; m_waited = 0;
        end
      end
      if (to_now) m_flag = 1;
      else if (timeout_clr) m_flag = 0;
    end
  end

  always @(negedge clk) begin : compare
    int sel;
    logic [3:0] e_scv, e_srr;
    logic e_cr;
    if (cmp_en) begin
      sel = int'(cmd_function_id[9:8]);
      e_scv = '0; e_cr = 1'b0; e_srr = m_stale;
      if (!m_have) begin
        if (m_busy >= 0) e_srr[m_busy] = 1'b1;
        else if (!EN[sel]) e_cr = 1'b1;
        else if (!m_stale[sel]) begin
          e_scv[sel] = cmd_valid;
          e_cr = s_cmd_ready[sel];
        end
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(m_have));
      chk("rsp_outputs_0", rsp_outputs_0, m_data);
      chk("timeout_flag", 32'(timeout_flag), 32'(m_flag));
      chk("cmd_int", 32'(cmd_int), 32'(m_int));
      chk("cmd_ready", 32'(cmd_ready), 32'(e_cr));
      chk("s_cmd_valid", 32'(s_cmd_valid), 32'(e_scv));
      chk("s_rsp_ready", 32'(s_rsp_ready), 32'(e_srr));
      chk("s_cmd_bcast", {s_cmd_function_id, s_cmd_inputs_0[21:0]},
          {cmd_function_id, cmd_inputs_0[21:0]});
      chk("s_cmd_in1", s_cmd_inputs_1, cmd_inputs_1);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  task automatic issue(input logic [9:0] id, input logic [3:0] rdy);
    cmd_function_id = id; s_cmd_ready = rdy; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; s_cmd_ready = '0;
  endtask

  task automatic respond(input int slot, input logic [31:0] d);
    set_slot(slot, d);
    s_rsp_valid = 4'(1 << slot);
    tick();
    s_rsp_valid = '0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1; cmd_valid = 0; cmd_function_id = '0; cmd_inputs_0 = 32'h0101_0101;
    cmd_inputs_1 = 32'h0202_0202; rsp_ready = 0; s_cmd_ready = '0; s_rsp_valid = '0;
    s_rsp_outputs_0 = '0; s_cmd_int = '0; timeout_clr = 0;
    tick(); tick();
    reset = 0;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_outputs_0, 32'd0);
    chk("reset_flag", 32'(timeout_flag), 32'd0);

    // Slot 0 normal round trip
    cmd_function_id = 10'h005; s_cmd_ready = 4'b0001; cmd_valid = 1; #1;
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t1_s_cmd_valid", 32'(s_cmd_valid), 32'b0001);
    tick();
    cmd_valid = 0; s_cmd_ready = '0; #1;
    chk("t1_s_rsp_ready", 32'(s_rsp_ready), 32'b0001);
    respond(0, 32'h1234_5678);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data", rsp_outputs_0, 32'h1234_5678);
    take_rsp();

    // Disabled slot 2
    cmd_function_id = 10'h2A0; cmd_valid = 1; #1;
    chk("t2_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t2_s_cmd_valid", 32'(s_cmd_valid), 32'd0);
    tick();
    cmd_valid = 0;
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_data", rsp_outputs_0, ERR);
    take_rsp();

    // Interrupt aggregation masks disabled slots
    s_cmd_int = 4'b0100; tick(); tick();
    chk("int_masked", 32'(cmd_int), 32'd0);
    s_cmd_int = 4'b0010; tick();
    chk("int_set", 32'(cmd_int), 32'd1);
    s_cmd_int = '0; tick();

    // CPU stalls the response for 10 cycles while a new command waits
    issue(10'h005, 4'b0001);
    respond(0, 32'h55AA_0F0F);
    cmd_function_id = 10'h005; s_cmd_ready = 4'b0001; cmd_valid = 1;
    repeat (10) begin
      #1;
      chk("t4_hold_ready", 32'(cmd_ready), 32'd0);
      chk("t4_hold_data", rsp_outputs_0, 32'h55AA_0F0F);
      tick();
    end
    cmd_valid = 0; s_cmd_ready = '0;
    take_rsp();

    // Slot 1 never answers
    issue(10'h100, 4'b0010);
    wait_rsp(n);
    chk("t3_timeout_latency", 32'(n), 32'd16);
    chk("t3_rsp_data", rsp_outputs_0, ERR);
    chk("t3_flag", 32'(timeout_flag), 32'd1);
    take_rsp();

    // Held until slot 1's late response is dropped
    cmd_function_id = 10'h100; s_cmd_ready = 4'b0010; cmd_valid = 1;
    repeat (3) begin
      #1;
      chk("t3_held", 32'(cmd_ready), 32'd0);
      tick();
    end
    set_slot(1, 32'hAAAA_AAAA); s_rsp_valid = 4'b0010; #1;
    chk("t3_stale_ready", 32'(s_rsp_ready), 32'b0010);
    tick();
    s_rsp_valid = '0; #1;
    chk("t3_release", 32'(cmd_ready), 32'd1);
    chk("t3_dropped", 32'(rsp_valid), 32'd0);
    tick();
    cmd_valid = 0; s_cmd_ready = '0;
    respond(1, 32'h0BAD_F00D);
    chk("t3_after_data", rsp_outputs_0, 32'h0BAD_F00D);
    take_rsp();
    timeout_clr = 1; tick(); timeout_clr = 0;
    chk("flag_cleared", 32'(timeout_flag), 32'd0);

    // Response lands in the expiry cycle
    issue(10'h005, 4'b0001);
    repeat (15) tick();
    respond(0, 32'hCAFE_0001);
    chk("t5_data", rsp_outputs_0, 32'hCAFE_0001);
    chk("t5_flag", 32'(timeout_flag), 32'd0);
    take_rsp();

    // Timeout set beats a simultaneous clear
    timeout_clr = 1;
    issue(10'h005, 4'b0001);
    wait_rsp(n);
    chk("set_wins_flag", 32'(timeout_flag), 32'd1);
    timeout_clr = 0;
    take_rsp();
    respond(0, 32'h7777_7777);

    // Reset while waiting abandons the command
    issue(10'h005, 4'b0001);
    tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_flag", 32'(timeout_flag), 32'd0);
    repeat (3) tick();
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    issue(10'h040, 4'b0001);
    respond(0, 32'h600D_0006);
    chk("t6_fresh_data", rsp_outputs_0, 32'h600D_0006);
    take_rsp();

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmd_router.md
Name: cmd_router

Overview:
- Parametrised custom-instruction router between the CPU custom-instruction port and up to NUM_SLOTS accelerator or user slots.
- Decodes the top bits of cmd_function_id to pick a slot. Allows one outstanding command at a time and registers the response back to the CPU.
- Adds features the fixed two-way split lacks:
  - per-slot enable mask; unmapped slots get an error response
  - response watchdog that returns an error on timeout
  - stale-slot tracking that drops late responses
  - registered, masked interrupt aggregation

Parameters:
NUM_SLOTS, 4, number of slots; power of 2, range 2..16; SEL_W = log2(NUM_SLOTS)
SLOT_EN, 4'b0011, bit i=1 means slot i is populated; must be NUM_SLOTS bits wide
TIMEOUT_CYCLES, 1024, response watchdog limit in clk cycles; 0 disables the watchdog
ERR_RSP, 32'hDEAD_0BAD, value returned on rsp_outputs_0 for an unmapped slot or a timeout

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  CPU command valid
cmd_function_id  in  10  function id; slot = cmd_function_id[9 -: SEL_W]
cmd_inputs_0  in  32  operand 0
cmd_inputs_1  in  32  operand 1
cmd_ready  out  1  command accepted
rsp_valid  out  1  response valid (registered)
rsp_outputs_0  out  32  response data (registered)
rsp_ready  in  1  CPU accepts response
cmd_int  out  1  registered OR of the enabled slot interrupts
s_cmd_valid  out  NUM_SLOTS  one-hot command valid per slot
s_cmd_ready  in  NUM_SLOTS  slot command ready
s_cmd_function_id  out  10  broadcast function id
s_cmd_inputs_0  out  32  broadcast operand 0
s_cmd_inputs_1  out  32  broadcast operand 1
s_rsp_valid  in  NUM_SLOTS  slot response valid
s_rsp_outputs_0  in  32*NUM_SLOTS  slot responses; slot i occupies [32i+31:32i]
s_rsp_ready  out  NUM_SLOTS  slot response ready
s_cmd_int  in  NUM_SLOTS  slot interrupts
timeout_flag  out  1  sticky flag: a timeout has occurred
timeout_clr  in  1  clears timeout_flag

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_outputs_0=0, cmd_int=0, timeout_flag=0
  - stale mask=0, state=IDLE, timer=0
  - reset mid-operation abandons the command; no response is issued
- Combinational outputs:
  - s_cmd_valid, cmd_ready and s_rsp_ready are combinational from state and inputs; the broadcast s_cmd_* buses pass straight through.
  - No other outputs are combinational.
- FSM state IDLE:
  - sel = cmd_function_id[9 -: SEL_W]
  - If SLOT_EN[sel]=1 and stale[sel]=0: s_cmd_valid[sel]=cmd_valid, cmd_ready=s_cmd_ready[sel]. On handshake, latch sel as own, clear timer, go WAIT.
  - If SLOT_EN[sel]=0: cmd_ready=1, no slot is driven. On cmd_valid, load ERR_RSP into the response register, set rsp_valid, go RSP.
  - If stale[sel]=1: cmd_ready=0 and the command is held.
- FSM state WAIT:
  - s_rsp_ready[own]=1; cmd_ready=0.
  - On s_rsp_valid[own]: capture s_rsp_outputs_0 of slot own, set rsp_valid, go RSP.
  - Otherwise the timer increments. When timer reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): load ERR_RSP, set rsp_valid, set timeout_flag, set stale[own], go RSP.
  - If s_rsp_valid[own] and timeout expiry coincide, the response wins: no stale, no flag.
- FSM state RSP:
  - rsp_valid held with data stable until rsp_ready. On handshake, clear rsp_valid and go IDLE.
  - cmd_ready=0 in RSP, so there is no same-cycle back-to-back acceptance.
- Stale slots:
  - In any state, s_rsp_ready[i]=1 for every i with stale[i]=1.
  - An s_rsp_valid on such a slot is dropped and clears stale[i].
  - Non-own, non-stale slots always have s_rsp_ready=0.
- Latency:
  - command handshake in cycle N; earliest slot response in cycle N+1; rsp_valid in N+2
  - unmapped slot: rsp_valid in N+1
- timeout_flag:
  - If timeout_clr is asserted in the same cycle as a new timeout, set wins.
- cmd_int = registered |(s_cmd_int & SLOT_EN), one cycle of latency.
- Timer width: clog2(TIMEOUT_CYCLES+1); the timer saturates and never wraps.

Decomposition:
- Package cmd_router_pkg holds:
  - state enum {IDLE, WAIT, RSP}
  - FUNC_ID_W=10, DATA_W=32
  - default ERR_RSP
  - function sel_of(function_id, SEL_W)
- Sub-module cmd_router_wdog: loadable counter with clear, enable and expire outputs, parametrised by TIMEOUT_CYCLES. A TIMEOUT_CYCLES=0 instance never expires.

Test Plan:
- NUM_SLOTS=4, SLOT_EN=4'b0011. Command id=10'h005 (slot 0); slot 0 responds 32'h1234_5678 one cycle after handshake -> rsp_valid two cycles after handshake, rsp_outputs_0=32'h1234_5678, only s_cmd_valid[0] ever high.
- Command id=10'h2A0 (slot 2, disabled) -> cmd_ready=1 immediately; next cycle rsp_valid=1 with 32'hDEAD_0BAD; no s_cmd_valid bit asserted.
- TIMEOUT_CYCLES=16; slot 1 never responds -> rsp=ERR_RSP 16 cycles after the handshake, timeout_flag=1.
  - A later command to slot 1 is held (cmd_ready=0) until slot 1 pulses s_rsp_valid=32'hAAAA_AAAA; that data is dropped, stale clears and the held command proceeds.
- rsp_ready held low for 10 cycles -> rsp_valid and data stay stable; a new cmd_valid gets cmd_ready=0 until the response handshake.
- Slot response arrives exactly in the expiry cycle -> the slot data is returned, timeout_flag stays 0.
- reset pulsed while in WAIT -> all outputs return to reset values, no response is issued, and a fresh command completes normally.
